// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for a three-digit, common-anode, seven-segment display.
//   Each digit is shown for DIV clk cycles, scanning 0 -> 1 -> 2 -> 0.
//   A "frame" is one full pass over the three digits.
//   New values are double-buffered: a load is held in a pending register and is
//   copied to the display register only at a frame boundary, so a frame never
//   mixes digits from two different values.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   value       three hex nibbles; [3:0] is digit 0 (rightmost)
//   dp_mask     decimal-point request per digit, 1 = lit
//   load        one-cycle strobe that captures value/dp_mask
//   blank_lz    leading-zero blanking enable
//   enable      0 forces all anodes off; the scan keeps running
//   seg         active-low cathodes, [6:0] = g..a, [7] = dp
//   an          active-low anodes, an[i] selects digit i
//   pending     a captured value is waiting for the next frame boundary
//   frame_sync  one-cycle pulse in the cycle after each frame boundary
module seg_scan_driver #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] value,
    input  logic [2:0]  dp_mask,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [7:0]  seg,
    output logic [2:0]  an,
    output logic        pending,
    output logic        frame_sync
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [11:0]   r_disp_val;
    logic [2:0]    r_disp_dp;
    logic [11:0]   r_pend_val;
    logic [2:0]    r_pend_dp;
    logic          r_pend;
    logic          r_fs;
    logic [7:0]    r_seg;
    logic [2:0]    r_an;

    logic          w_tick;
    logic          w_bound;
    logic [3:0]    w_nib;
    logic          w_dp;
    logic          w_blank;
    logic [7:0]    w_seg_next;
    logic [2:0]    w_an_next;

    assign w_tick  = (r_presc == PW'(DIV - 1));
    assign w_bound = w_tick && (r_idx == 2'd2);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (r_idx == 2'd3)
                r_idx <= 2'd0;
            else if (w_tick)
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end
    end

    // A load landing exactly on the boundary goes straight to the display
    // register and supersedes anything still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
            r_fs       <= 1'b0;
        end else begin
            r_fs <= w_bound;
            if (w_bound) begin
                r_pend <= 1'b0;
                if (load) begin
                    r_disp_val <= value;
                    r_disp_dp  <= dp_mask;
                end else if (r_pend) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_mask;
                r_pend     <= 1'b1;
            end
        end
    end

    always_comb begin
        w_nib   = r_disp_val[3:0];
        w_dp    = r_disp_dp[0];
        w_blank = 1'b0;
        case (r_idx)
            2'd1: begin
                w_nib   = r_disp_val[7:4];
                w_dp    = r_disp_dp[1];
                w_blank = blank_lz && (r_disp_val[11:4] == 8'h00);
            end
            2'd2: begin
                w_nib   = r_disp_val[11:8];
                w_dp    = r_disp_dp[2];
                w_blank = blank_lz && (r_disp_val[11:8] == 4'h0);
            end
            default: ;
        endcase
        w_seg_next = w_blank ? 8'hFF : {~w_dp, hex7(w_nib)};
        // idx 3 shifts the one-hot out of range, which leaves every anode off
        w_an_next  = enable ? ~(3'b001 << r_idx) : 3'b111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 8'hFF;
            r_an  <= 3'b111;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign pending    = r_pend;
    assign frame_sync = r_fs;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] value = '0;
    logic [2:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  seg;
    logic [2:0]  an;
    logic        pending;
    logic        frame_sync;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
        .load(load), .blank_lz(blank_lz), .enable(enable),
        .seg(seg), .an(an), .pending(pending), .frame_sync(frame_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // Segment patterns with dp off, index = hex digit
    logic [7:0] hexp [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [7:0] digit_seg(input int d, input logic [11:0] v,
                                             input logic [2:0] dp, input logic bl);
        logic [3:0] nib;
        logic [7:0] pat;
        nib = 4'((v >> (4 * d)) & 12'h00F);
        if (bl && d == 2 && v[11:8] == 4'h0) return 8'hFF;
        if (bl && d == 1 && v[11:4] == 8'h00) return 8'hFF;
        pat = hexp[nib];
        return {~dp[d], pat[6:0]};
    endfunction

    // Model: k counts clock edges since reset release; everything else is
    // derived from that count arithmetically.
    int unsigned k = 0;
    logic [11:0] m_dval = '0, m_pval = '0;
    logic [2:0]  m_ddp = '0, m_pdp = '0;
    logic        m_pend = 1'b0;
    logic [7:0]  e_seg = 8'hFF;
    logic [2:0]  e_an = 3'b111;
    logic        e_fs = 1'b0, e_pend = 1'b0;

    always @(negedge clk) begin
        int idx;
        bit bnd;
        if (!rst_n) begin
            chk("rst_seg", seg, 8'hFF);
            chk("rst_an", an, 3'b111);
            chk("rst_pending", pending, 1'b0);
            chk("rst_fs", frame_sync, 1'b0);
            k = 0; m_dval = '0; m_pval = '0; m_ddp = '0; m_pdp = '0; m_pend = 1'b0;
            e_seg = 8'hFF; e_an = 3'b111; e_fs = 1'b0; e_pend = 1'b0;
        end else begin
            chk("seg", seg, e_seg);
            chk("an", an, e_an);
            chk("pending", pending, e_pend);
            chk("frame_sync", frame_sync, e_fs);
            idx = int'((k / DIV) % 3);
            bnd = (k % (3 * DIV)) == (3 * DIV - 1);
            e_an  = !enable ? 3'b111 : (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
            e_seg = digit_seg(idx, m_dval, m_ddp, blank_lz);
            e_fs  = bnd;
            if (bnd) begin
                if (load) begin
                    m_dval = value; m_ddp = dp_mask;
                end else if (m_pend) begin
                    m_dval = m_pval; m_ddp = m_pdp;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pval = value; m_pdp = dp_mask; m_pend = 1'b1;
            end
            e_pend = m_pend;
            k++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_sync && n < 40);
        if (!frame_sync) tmo("wait_fs");
    endtask

    task automatic wait_digit(input int d);
        logic [2:0] t;
        int n = 0;
        t = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
        while (an == t && n < 40) begin step(); n++; end
        while (an != t && n < 40) begin step(); n++; end
        if (an != t) tmo("wait_digit");
    endtask

    task automatic pulse_load(input logic [11:0] v, input logic [2:0] dp);
        value = v; dp_mask = dp; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("first_an", an, 3'b110);
        chk("first_seg", seg, 8'hC0);

        // frame period
        wait_fs();
        n = 0;
        do begin step(); n++; end while (!frame_sync && n < 40);
        chk("fs_period", n, 12);

        // mid-frame load, shown from the next frame
        step(); step(); step();
        pulse_load(12'h1A8, 3'b001);
        chk("pend_set", pending, 1'b1);
        wait_fs();
        chk("pend_clr", pending, 1'b0);
        wait_digit(0); chk("d0_1A8", seg, 8'h00);
        wait_digit(1); chk("d1_1A8", seg, 8'h88);
        wait_digit(2); chk("d2_1A8", seg, 8'hF9);

        // last load wins
        wait_fs();
        step(); step();
        pulse_load(12'h111, 3'b000);
        step();
        pulse_load(12'h222, 3'b000);
        wait_fs();
        wait_digit(0); chk("d0_222", seg, 8'hA4);
        wait_digit(2); chk("d2_222", seg, 8'hA4);

        // load exactly on the boundary cycle
        wait_fs();
        repeat (11) step();
        pulse_load(12'hF00, 3'b000);
        chk("bypass_pend", pending, 1'b0);
        chk("bypass_fs", frame_sync, 1'b1);
        wait_digit(2); chk("d2_F00", seg, 8'h8E);
        wait_digit(0); chk("d0_F00", seg, 8'hC0);

        // leading-zero blanking
        blank_lz = 1'b1;
        step();
        pulse_load(12'h005, 3'b111);
        wait_fs();
        wait_digit(2); chk("blank_d2", seg, 8'hFF);
        wait_digit(1); chk("blank_d1", seg, 8'hFF);
        wait_digit(0); chk("d0_005", seg, 8'h12);
        pulse_load(12'h000, 3'b000);
        wait_fs();
        wait_digit(0); chk("d0_000", seg, 8'hC0);
        wait_digit(1); chk("blank_d1_000", seg, 8'hFF);
        blank_lz = 1'b0;
        pulse_load(12'h305, 3'b000);
        wait_fs();

        // enable low: anodes off, scan keeps its phase
        step();
        enable = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("an_off", an, 3'b111);
            step();
        end
        chk("an_off_last", an, 3'b111);
        enable = 1'b1;
        repeat (14) step();

        // async reset with pending data
        wait_fs();
        step(); step();
        pulse_load(12'h456, 3'b010);
        chk("pend_before_rst", pending, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_seg", seg, 8'hFF);
        chk("arst_an", an, 3'b111);
        chk("arst_pending", pending, 1'b0);
        chk("arst_fs", frame_sync, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_an", an, 3'b110);
        chk("post_rst_seg", seg, 8'hC0);
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
